// File: rtl/ysyx_22050039_mdu.sv
// Iterative RV64M/RV32M multiply/divide unit (shift-add multiply, restoring divide) beside the EXU.
// Latency: XLEN+1 cycles (33 for W ops); divide-by-zero, signed overflow and illegal ops take 1 cycle.
// Backpressure: result held in DONE until out_ready; in_ready only while IDLE; flush aborts at any time.
module ysyx_22050039_mdu #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op_funct3,
  input  logic            op_word,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            illegal
);

  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  // Multiply: acc accumulates the product, mcand is the left-shifting multiplicand,
  // mpl the right-shifting multiplier.
  // Divide: acc[XLEN-1:0] is the partial remainder, mcand[XLEN-1:0] the divisor,
  // mpl shifts dividend bits out at the top and quotient bits in at the bottom.
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] mcand;
  logic [XLEN-1:0]   mpl;
  logic [2:0]        f3_r;
  logic              word_r;
  logic              neg_r;     // sign of product / quotient
  logic              rneg_r;    // sign of remainder (follows the dividend)
  logic              byp_r;     // result was resolved at accept time
  logic              byp_ill_r;
  logic [XLEN-1:0]   byp_res;

  // Extend the low word to XLEN, sign-extending when sgn is set.
  function automatic logic [XLEN-1:0] ext32(input logic [31:0] x, input logic sgn);
    logic [XLEN-1:0] r;
    r = (sgn && x[31]) ? '1 : '0;
    r[31:0] = x;
    return r;
  endfunction

  logic            accept;
  logic            is_div, a_sgn, b_sgn, a_neg, b_neg;
  logic            bad_op, div0, ovf_a, ovf;
  logic [XLEN-1:0] op_a, op_b, a_mag, b_mag, dividend, spec_res;
  logic [CW-1:0]   n_iter;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && (state == IDLE) && !rst && !flush;

  // Decode the incoming request: operand extension, magnitudes, signs and special cases.
  always_comb begin
    is_div   = op_funct3[2];
    a_sgn    = is_div ? ~op_funct3[0] : (op_funct3[1:0] != 2'b11);
    b_sgn    = is_div ? ~op_funct3[0] : ~op_funct3[1];
    op_a     = op_word ? ext32(src1[31:0], a_sgn) : src1;
    op_b     = op_word ? ext32(src2[31:0], b_sgn) : src2;
    a_neg    = a_sgn & op_a[XLEN-1];
    b_neg    = b_sgn & op_b[XLEN-1];
    a_mag    = a_neg ? -op_a : op_a;
    b_mag    = b_neg ? -op_b : op_b;
    bad_op   = op_word && ((XLEN == 32) || (!is_div && (op_funct3[1:0] != 2'b00)));
    div0     = is_div && (op_b == '0);
    ovf_a    = op_word ? (src1[31:0] == 32'h8000_0000)
                       : (src1 == {1'b1, {(XLEN-1){1'b0}}});
    ovf      = is_div && ~op_funct3[0] && ovf_a && (op_b == '1);
    dividend = op_word ? ext32(src1[31:0], 1'b1) : src1;
    spec_res = '0;
    if (div0)
      spec_res = op_funct3[1] ? dividend : '1;
    else if (ovf)
      spec_res = op_funct3[1] ? '0 : dividend;
    n_iter   = op_word ? CW'(32) : CW'(XLEN);
  end

  logic [XLEN:0]     trial;
  logic              ge;
  logic [XLEN-1:0]   diff;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, sel, fix_res;

  // One restoring-division step, and the final sign correction / selection.
  always_comb begin
    trial = {acc[XLEN-1:0], mpl[XLEN-1]};
    ge    = trial >= {1'b0, mcand[XLEN-1:0]};
    // When ge holds the true difference is below the divisor, so XLEN bits suffice.
    diff  = trial[XLEN-1:0] - mcand[XLEN-1:0];
    prod  = neg_r ? -acc : acc;
    quo   = neg_r ? -mpl : mpl;
    rem   = rneg_r ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    if (f3_r[2])
      sel = f3_r[1] ? rem : quo;
    else
      sel = (f3_r[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    fix_res = word_r ? ext32(sel[31:0], 1'b1) : sel;
  end

  // Datapath: load magnitudes on accept, then one multiply or divide step per BUSY cycle.
  always_ff @(posedge clk) begin
    if (accept) begin
      f3_r      <= op_funct3;
      word_r    <= op_word;
      neg_r     <= a_neg ^ b_neg;
      rneg_r    <= a_neg;
      byp_r     <= bad_op | div0 | ovf;
      byp_ill_r <= bad_op;
      byp_res   <= bad_op ? '0 : spec_res;
      acc       <= '0;
      mcand     <= {{XLEN{1'b0}}, (is_div ? b_mag : a_mag)};
      // Word dividends are left-aligned so the 32 iterations consume their bits MSB first.
      mpl       <= is_div ? (op_word ? (a_mag << (XLEN - 32)) : a_mag) : b_mag;
    end else if (state == BUSY) begin
      if (f3_r[2]) begin
        acc[XLEN-1:0] <= ge ? diff : trial[XLEN-1:0];
        mpl           <= {mpl[XLEN-2:0], ge};
      end else begin
        if (mpl[0])
          acc <= acc + mcand;
        mcand <= mcand << 1;
        mpl   <= mpl >> 1;
      end
    end
  end

  // Control FSM with registered outputs; flush and reset both return to IDLE.
  // Resolved-at-accept ops spend one cycle in FIX so every result leaves through one register.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      illegal   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (bad_op || div0 || ovf) begin
              state <= FIX;
            end else begin
              state <= BUSY;
              cnt   <= n_iter;
            end
          end
        end
        BUSY: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1))
            state <= FIX;
        end
        FIX: begin
          result    <= byp_r ? byp_res : fix_res;
          illegal   <= byp_ill_r;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
